// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and baud divider math,
// common to the transmitter and the receiver.
package uart_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_START = START,
    ST_DATA  = DATA,
    ST_STOP  = STOP
  } uart_state_e;

  localparam int TICKS_PER_BIT = 16;

  // Clock cycles per oversampling tick, integer-truncated.
  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / (baud * TICKS_PER_BIT);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// 16x-oversampling tick generator: one-cycle o_tick every DIV clocks while
// i_en is high; the divider restarts from zero whenever i_en drops.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  output logic o_tick
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;
  logic          at_top;

  assign at_top = (cnt == CW'(DIV - 1));
  assign o_tick = i_en && at_top;

  always_ff @(posedge clk) begin
    if (reset || !i_en || at_top) cnt <= '0;
    else                          cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: FSM, shift register and bit/tick counters; the
// baud divider is gated by busy so every frame starts on a full-length bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_tx_busy,
  output logic       o_tx_done
);

  uart_state_e state;
  logic [7:0]  shift_reg;
  logic [2:0]  bit_idx;
  logic [3:0]  tick_cnt;
  logic        tick;
  logic        bit_end;

  baud_tick_gen #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .i_en   (o_tx_busy),
    .o_tick (tick)
  );

  // 16th tick of the current bit; tick_cnt wraps to 0 on the same edge.
  assign bit_end = tick && (tick_cnt == 4'd15);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      bit_idx   <= '0;
      tick_cnt  <= '0;
      o_tx      <= 1'b1;
      o_tx_busy <= 1'b0;
      o_tx_done <= 1'b0;
    end else begin
      o_tx_done <= 1'b0;
      if (tick) tick_cnt <= tick_cnt + 4'd1;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            shift_reg <= i_data;
            bit_idx   <= '0;
            tick_cnt  <= '0;
            o_tx      <= 1'b0;
            o_tx_busy <= 1'b1;
            state     <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            bit_idx <= '0;
            o_tx    <= shift_reg[0];
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            shift_reg <= shift_reg >> 1;
            if (bit_idx == 3'd7) begin
              o_tx  <= 1'b1;
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              o_tx    <= shift_reg[1];
            end
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            o_tx_busy <= 1'b0;
            o_tx_done <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx at DIV=10 (160 cycles/bit): table of frames plus
// hand-written abort, ignore, back-to-back and reset/start-collision cases.
module tb_uart_tx;

  localparam int CLK_FREQ  = 1_600_000;
  localparam int BAUD      = 10_000;
  localparam int BIT_CYC   = 160;
  localparam int FRAME_CYC = 10 * BIT_CYC;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_start = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       o_tx, o_tx_busy, o_tx_done;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  bit   mon_en = 1'b1;

  logic [7:0] exp_q[$];
  int         start_cyc[$];

  typedef struct {
    logic [7:0] data;
    int         done_at;
  } vec_t;
  vec_t vecs[6];

  uart_tx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_start   (i_start),
    .i_data    (i_data),
    .o_tx      (o_tx),
    .o_tx_busy (o_tx_busy),
    .o_tx_done (o_tx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (o_tx_done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Line monitor: pops the expected byte at each start bit, checks every
  // cycle of all 10 bits, mid-bit decodes the byte, and checks the done pulse.
  initial begin : monitor
    logic       prev;
    logic [9:0] fb;
    logic [7:0] d, dec;
    logic       bad, dbad;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && !reset && prev && (o_tx === 1'b0)) begin
        start_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected frame: start bit at cycle %0d, want no frame", cyc);
        end else begin
          d    = exp_q.pop_front();
          fb   = {1'b1, d, 1'b0};
          bad  = 1'b0;
          dbad = 1'b0;
          dec  = '0;
          for (int b = 0; b < 10; b++) begin
            for (int k = 0; k < BIT_CYC; k++) begin
              if (b != 0 || k != 0) @(negedge clk);
              if (o_tx !== fb[b]) bad = 1'b1;
              if (o_tx_done !== 1'b0) dbad = 1'b1;
              if (k == BIT_CYC / 2 && b >= 1 && b <= 8) dec[b-1] = o_tx;
            end
          end
          check("frame level/length", bad, 0);
          check("decoded byte", dec, d);
          check("done low in frame", dbad, 0);
          @(negedge clk);
          check("done at frame end", o_tx_done, 1);
          check("line high after frame", o_tx, 1);
        end
      end
      prev = o_tx;
    end
  end

  // Called at a negedge while idle; returns the negedge count to o_tx_done.
  task automatic send(input logic [7:0] d, output int n);
    exp_q.push_back(d);
    i_data  = d;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_data  = ~d;
    n = 1;
    check("busy after accept", o_tx_busy, 1);
    while (o_tx_done !== 1'b1 && n < 2 * FRAME_CYC) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin : main
    int n, d0, sc, lows;
    vecs[0] = '{8'h41, FRAME_CYC + 1};
    vecs[1] = '{8'hA5, FRAME_CYC + 1};
    vecs[2] = '{8'h00, FRAME_CYC + 1};
    vecs[3] = '{8'hFF, FRAME_CYC + 1};
    vecs[4] = '{8'h80, FRAME_CYC + 1};
    vecs[5] = '{8'h01, FRAME_CYC + 1};

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset o_tx", o_tx, 1);
    check("reset busy", o_tx_busy, 0);
    check("reset done", o_tx_done, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      send(vecs[i].data, n);
      check("done latency", n, vecs[i].done_at);
      @(negedge clk);
      check("done single cycle", o_tx_done, 0);
      check("busy low after frame", o_tx_busy, 0);
    end

    // i_start during a frame is dropped, not queued
    d0 = done_cnt;
    exp_q.push_back(8'h55);
    i_data  = 8'h55;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (500) @(negedge clk);
    i_data  = 8'hFF;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (300) @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (FRAME_CYC + 200) @(negedge clk);
    check("one done for 0x55", done_cnt - d0, 1);
    check("no queued frame", o_tx_busy, 0);

    // held i_start: back-to-back frames, one idle cycle apart
    d0 = done_cnt;
    sc = start_cyc.size();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    i_data  = 8'h00;
    i_start = 1'b1;
    repeat (3000) @(negedge clk);
    i_start = 1'b0;
    repeat (600) @(negedge clk);
    check("held start done count", done_cnt - d0, 2);
    check("held start frame count", start_cyc.size() - sc, 2);
    if (start_cyc.size() - sc >= 2)
      check("frame start spacing", start_cyc[sc+1] - start_cyc[sc], FRAME_CYC + 1);
    check("held start idle", o_tx_busy, 0);

    // reset mid-frame in data bit 3 (cycles 641..800 after accept)
    mon_en = 1'b0;
    d0 = done_cnt;
    i_data  = 8'hF0;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (699) @(negedge clk);
    check("bit3 of 0xF0 low", o_tx, 0);
    check("busy in bit3", o_tx_busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort o_tx", o_tx, 1);
    check("abort busy", o_tx_busy, 0);
    reset = 1'b0;
    lows = 0;
    repeat (2000) begin
      @(negedge clk);
      if (o_tx !== 1'b1) lows++;
    end
    check("abort no done", done_cnt - d0, 0);
    check("abort line idle", lows, 0);
    mon_en = 1'b1;

    // reset and i_start together: reset wins
    d0 = done_cnt;
    reset   = 1'b1;
    i_start = 1'b1;
    i_data  = 8'h00;
    @(negedge clk);
    reset   = 1'b0;
    i_start = 1'b0;
    check("collision busy", o_tx_busy, 0);
    lows = 0;
    repeat (20_000) begin
      @(negedge clk);
      if (o_tx !== 1'b1) lows++;
    end
    check("collision line idle", lows, 0);
    check("collision no done", done_cnt - d0, 0);

    check("scoreboard drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, serial bit rate in bit/s.
REQ-003 Port clk  input  1  system clock; all logic on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port i_start  input  1  transmit request, driven by the debounced button output; sampled only in IDLE.
REQ-006 Port i_data  input  8  byte to transmit; latched in the cycle i_start is accepted.
REQ-007 Port o_tx  output  1  serial line; idle high, registered.
REQ-008 Port o_tx_busy  output  1  high from the cycle after acceptance until the frame ends.
REQ-009 Port o_tx_done  output  1  single-cycle pulse at frame end.

Function
REQ-010 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-011 Tick divider SHALL be DIV = CLK_FREQ/(BAUD*16), integer-truncated; defaults give DIV = 651.
REQ-012 Each bit SHALL last exactly 16 ticks = 16*DIV clk cycles; defaults give 10416 cycles per bit and 104160 per frame.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-014 IDLE: o_tx=1, o_tx_busy=0; i_start=1 -> latch i_data, clear tick divider and tick counter, go to START.
REQ-015 START: o_tx=0 beginning the cycle after acceptance (1-cycle latency); after 16 ticks go to DATA with bit index 0.
REQ-016 DATA: o_tx=shift_reg[0]; after 16 ticks shift right and increment index; after index 7 completes go to STOP.
REQ-017 STOP: o_tx=1; after 16 ticks assert o_tx_done for exactly one cycle and return to IDLE in the same cycle.
REQ-018 i_start while not in IDLE SHALL be ignored with no queuing; i_data changes during a frame SHALL NOT affect it.
REQ-019 i_start held high continuously SHALL start a new frame on the first IDLE cycle, producing back-to-back frames with one idle-high cycle between them.
REQ-020 Tick divider SHALL run only while busy; first bit SHALL be full length, never truncated.
REQ-021 Bit index SHALL be 3 bits with no wrap beyond 7; the tick counter SHALL be 4 bits and wrap 15->0 at each bit boundary.

Reset
REQ-022 On reset: state=IDLE, o_tx=1, o_tx_busy=0, o_tx_done=0, all counters and the shift register cleared.
REQ-023 Reset asserted mid-frame SHALL abort the frame, with o_tx high on the next cycle and no o_tx_done pulse.
REQ-024 Reset and i_start asserted in the same cycle: reset SHALL win and no frame starts.

Structure
REQ-025 State encoding localparams (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3) SHALL live in shared file uart_pkg, reused by the future uart_rx.
REQ-026 Tick generation SHALL be a sub-module baud_tick_gen (clk, reset, i_en, o_tick) with parameters CLK_FREQ and BAUD; o_tick is a 1-cycle pulse every DIV cycles while i_en=1.
REQ-027 uart_tx SHALL contain only the FSM, the shift register, and the counters.

Verification
REQ-028 Reset 1 for 10 ns, then i_start pulse with i_data=8'h41 -> o_tx sequence 0,1,0,0,0,0,0,1,0,1, each bit 10416 cycles; o_tx_done 1 cycle at 104160 cycles after acceptance.
REQ-029 i_start pulse mid-frame with i_data=8'hFF during an 8'h55 frame -> waveform unchanged, exactly one o_tx_done.
REQ-030 i_start held high for 250_000 cycles with i_data=8'h00 -> at least two complete frames, each separated by one idle-high cycle.
REQ-031 Reset asserted in DATA at bit 3 -> o_tx=1 and o_tx_busy=0 the next cycle; no o_tx_done.
REQ-032 Reset and i_start asserted together -> o_tx stays 1 for 20_000 cycles afterward.
REQ-033 Bench with CLK_FREQ=1_600_000, BAUD=10_000 (DIV=10) and i_data=8'hA5 -> 160 cycles per bit; bits decoded by a sampler equal 8'hA5.
